// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline tracker: stage record, RF select code
// and the saturating counter increment.
package pipe_pkg;

    localparam int PIPE_REG_W = 5;
    localparam int PIPE_STG_W = 2;

    // fwd select value meaning "read the register file"
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                  valid;
        logic [PIPE_REG_W-1:0] rd;
        logic                  we;
        logic [PIPE_STG_W-1:0] rdy;
    } stage_entry_t;

    // Width-agnostic: callers widen their counter to 64 bits and pass its all-ones value.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] max_value);
        return (value >= max_value) ? max_value : value + 64'd1;
    endfunction

endpackage

// File: rtl/pipe_tracker_if.sv
// Decode-side and datapath-side signals of the pipeline tracker.
interface pipe_tracker_if #(
    parameter int STAGES           = 4,
    parameter int REG_ADDRESS_SIZE = 5,
    parameter int STG_SIZE         = 2,
    parameter int FWD_SIZE         = 3,
    parameter int CNT_SIZE         = 32
);
    logic                        D_valid;
    logic [REG_ADDRESS_SIZE-1:0] D_addr_r1;
    logic [REG_ADDRESS_SIZE-1:0] D_addr_r2;
    logic                        D_use_r1;
    logic                        D_use_r2;
    logic [REG_ADDRESS_SIZE-1:0] D_addr_rd;
    logic                        D_We;
    logic [STG_SIZE-1:0]         D_rdy;
    logic                        hold;
    logic                        br_taken;

    logic                        D_stall;
    logic [FWD_SIZE-1:0]         fwd1;
    logic [FWD_SIZE-1:0]         fwd2;
    logic                        PC_clear;
    logic [STAGES-1:0]           stage_valid;
    logic [CNT_SIZE-1:0]         stall_cnt;
    logic [CNT_SIZE-1:0]         flush_cnt;
    logic [CNT_SIZE-1:0]         retire_cnt;

    modport master (
        output D_valid, D_addr_r1, D_addr_r2, D_use_r1, D_use_r2,
               D_addr_rd, D_We, D_rdy, hold, br_taken,
        input  D_stall, fwd1, fwd2, PC_clear, stage_valid,
               stall_cnt, flush_cnt, retire_cnt
    );

    modport slave (
        input  D_valid, D_addr_r1, D_addr_r2, D_use_r1, D_use_r2,
               D_addr_rd, D_We, D_rdy, hold, br_taken,
        output D_stall, fwd1, fwd2, PC_clear, stage_valid,
               stall_cnt, flush_cnt, retire_cnt
    );

endinterface

// File: rtl/pipe_fwd_lookup.sv
// Finds the youngest in-flight writer of one source register and reports either
// the forwarding stage or a not-yet-ready hazard.
module pipe_fwd_lookup
    import pipe_pkg::*;
#(
    parameter int STAGES           = 4,
    parameter int REG_ADDRESS_SIZE = 5,
    parameter int FWD_SIZE         = 3
) (
    input  stage_entry_t                entries [STAGES],
    input  logic [REG_ADDRESS_SIZE-1:0] src,
    input  logic                        use_src,
    output logic [FWD_SIZE-1:0]         fwd,
    output logic                        hazard
);

    // Walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        fwd    = FWD_SIZE'(FWD_RF);
        hazard = 1'b0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            if (use_src && (src != '0) && entries[s].valid && entries[s].we &&
                (entries[s].rd == src)) begin
                if (s >= int'(entries[s].rdy)) begin
                    fwd    = FWD_SIZE'(s + 1);
                    hazard = 1'b0;
                end else begin
                    fwd    = FWD_SIZE'(FWD_RF);
                    hazard = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_tracker.sv
// In-order pipeline tracker: per-stage destination records driving decode stall,
// operand forwarding, branch flush and saturating performance counters.
module pipe_tracker
    import pipe_pkg::*;
#(
    parameter int STAGES           = 4,
    parameter int REG_ADDRESS_SIZE = 5,
    parameter int STG_SIZE         = 2,
    parameter int FWD_SIZE         = 3,
    parameter int BRANCH_STAGE     = 2,
    parameter int CNT_SIZE         = 32
) (
    input  logic           clk,
    input  logic           reset,
    pipe_tracker_if.slave  bus
);

    localparam logic [63:0] CNT_MAX = 64'({CNT_SIZE{1'b1}});

    stage_entry_t                entries [STAGES];
    logic [FWD_SIZE-1:0]         fwd1_w;
    logic [FWD_SIZE-1:0]         fwd2_w;
    logic                        hazard1;
    logic                        hazard2;
    logic                        flush;
    logic                        stall;
    logic [REG_ADDRESS_SIZE-1:0] d_rd;
    logic [STG_SIZE-1:0]         d_rdy;
    logic [STAGES-1:0]           valid_vec;
    logic [CNT_SIZE-1:0]         stall_cnt;
    logic [CNT_SIZE-1:0]         flush_cnt;
    logic [CNT_SIZE-1:0]         retire_cnt;

    pipe_fwd_lookup #(
        .STAGES           (STAGES),
        .REG_ADDRESS_SIZE (REG_ADDRESS_SIZE),
        .FWD_SIZE         (FWD_SIZE)
    ) u_fwd1 (
        .entries (entries),
        .src     (bus.D_addr_r1),
        .use_src (bus.D_use_r1),
        .fwd     (fwd1_w),
        .hazard  (hazard1)
    );

    pipe_fwd_lookup #(
        .STAGES           (STAGES),
        .REG_ADDRESS_SIZE (REG_ADDRESS_SIZE),
        .FWD_SIZE         (FWD_SIZE)
    ) u_fwd2 (
        .entries (entries),
        .src     (bus.D_addr_r2),
        .use_src (bus.D_use_r2),
        .fwd     (fwd2_w),
        .hazard  (hazard2)
    );

    assign d_rd  = bus.D_addr_rd;
    assign d_rdy = bus.D_rdy;

    assign flush = bus.br_taken && entries[BRANCH_STAGE].valid && !bus.hold;
    assign stall = ((hazard1 || hazard2) && bus.D_valid) || bus.hold;

    always_comb begin
        valid_vec = '0;
        for (int s = 0; s < STAGES; s++) begin
            valid_vec[s] = entries[s].valid;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < STAGES; s++) begin
                entries[s] <= '0;
            end
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (!bus.hold) begin
                // A taken branch kills everything younger than itself: the entries
                // now in stages 0..BRANCH_STAGE-1 become bubbles as they shift.
                for (int s = 1; s < STAGES; s++) begin
                    if (flush && (s <= BRANCH_STAGE)) begin
                        entries[s] <= '0;
                    end else begin
                        entries[s] <= entries[s-1];
                    end
                end
                if (flush || stall || !bus.D_valid) begin
                    entries[0] <= '0;
                end else begin
                    entries[0] <= '{valid: 1'b1, rd: d_rd, we: bus.D_We, rdy: d_rdy};
                end
            end
            if (stall) begin
                stall_cnt <= CNT_SIZE'(sat_inc(64'(stall_cnt), CNT_MAX));
            end
            if (flush) begin
                flush_cnt <= CNT_SIZE'(sat_inc(64'(flush_cnt), CNT_MAX));
            end
            if (entries[STAGES-1].valid && !bus.hold) begin
                retire_cnt <= CNT_SIZE'(sat_inc(64'(retire_cnt), CNT_MAX));
            end
        end
    end

    assign bus.D_stall     = stall;
    assign bus.fwd1        = fwd1_w;
    assign bus.fwd2        = fwd2_w;
    assign bus.PC_clear    = flush;
    assign bus.stage_valid = valid_vec;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.flush_cnt   = flush_cnt;
    assign bus.retire_cnt  = retire_cnt;

endmodule

// File: tb/tb_pipe_tracker.sv
// Directed bench for pipe_tracker with an instruction-level reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_pipe_tracker;

    localparam int STAGES       = 4;
    localparam int BRANCH_STAGE = 2;
    localparam longint CNT_MAX  = 64'hFFFF_FFFF;

    logic clk;
    logic rst_n;

    pipe_tracker_if #(
        .STAGES(4), .REG_ADDRESS_SIZE(5), .STG_SIZE(2), .FWD_SIZE(3), .CNT_SIZE(32)
    ) bus ();

    pipe_tracker #(
        .STAGES(4), .REG_ADDRESS_SIZE(5), .STG_SIZE(2), .FWD_SIZE(3),
        .BRANCH_STAGE(2), .CNT_SIZE(32)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: instructions in flight ----------------
    typedef struct {
        bit v;
        int rd;
        bit we;
        int rdy;
    } ment_t;

    ment_t  m [STAGES];
    longint m_stall  = 0;
    longint m_flush  = 0;
    longint m_retire = 0;

    function automatic void lookup(input bit use_s, input int r, output int fwd, output bit hz);
        fwd = 0;
        hz  = 1'b0;
        if (!use_s || r == 0) return;
        for (int s = 0; s < STAGES; s++) begin
            if (m[s].v && m[s].we && m[s].rd == r) begin
                if (s >= m[s].rdy) fwd = s + 1;
                else               hz  = 1'b1;
                return;
            end
        end
    endfunction

    function automatic bit exp_stall();
        int f1, f2;
        bit h1, h2;
        lookup(bus.D_use_r1, int'(bus.D_addr_r1), f1, h1);
        lookup(bus.D_use_r2, int'(bus.D_addr_r2), f2, h2);
        return ((h1 || h2) && bus.D_valid) || bus.hold;
    endfunction

    function automatic bit exp_flush();
        return bus.br_taken && m[BRANCH_STAGE].v && !bus.hold;
    endfunction

    function automatic ment_t next_ent(input int s);
        ment_t e;
        e = '{default: 0};
        if (bus.hold) return m[s];
        if (s == 0) begin
            if (!exp_flush() && !exp_stall() && bus.D_valid) begin
                e.v   = 1'b1;
                e.rd  = int'(bus.D_addr_rd);
                e.we  = bus.D_We;
                e.rdy = int'(bus.D_rdy);
            end
            return e;
        end
        // instructions younger than a taken branch never reach the next stage
        if (exp_flush() && (s - 1) < BRANCH_STAGE) return e;
        return m[s-1];
    endfunction

    function automatic longint sat(input longint v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) m[s] <= '{default: 0};
            m_stall  <= 0;
            m_flush  <= 0;
            m_retire <= 0;
        end else begin
            for (int s = 0; s < STAGES; s++) m[s] <= next_ent(s);
            m_stall  <= sat(m_stall + (exp_stall() ? 1 : 0));
            m_flush  <= sat(m_flush + (exp_flush() ? 1 : 0));
            m_retire <= sat(m_retire + ((m[STAGES-1].v && !bus.hold) ? 1 : 0));
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int  f1, f2;
        bit  h1, h2;
        logic [STAGES-1:0] sv;
        lookup(bus.D_use_r1, int'(bus.D_addr_r1), f1, h1);
        lookup(bus.D_use_r2, int'(bus.D_addr_r2), f2, h2);
        for (int s = 0; s < STAGES; s++) sv[s] = m[s].v;
        chk("cyc_D_stall",     bus.D_stall,     exp_stall());
        chk("cyc_fwd1",        bus.fwd1,        f1);
        chk("cyc_fwd2",        bus.fwd2,        f2);
        chk("cyc_PC_clear",    bus.PC_clear,    exp_flush());
        chk("cyc_stage_valid", bus.stage_valid, sv);
        chk("cyc_stall_cnt",   bus.stall_cnt,   m_stall);
        chk("cyc_flush_cnt",   bus.flush_cnt,   m_flush);
        chk("cyc_retire_cnt",  bus.retire_cnt,  m_retire);
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.D_valid   = 1'b0;
        bus.D_addr_r1 = '0;
        bus.D_addr_r2 = '0;
        bus.D_use_r1  = 1'b0;
        bus.D_use_r2  = 1'b0;
        bus.D_addr_rd = '0;
        bus.D_We      = 1'b0;
        bus.D_rdy     = '0;
        bus.hold      = 1'b0;
        bus.br_taken  = 1'b0;
    endtask

    task automatic issue(input int rd, input bit we, input int rdy,
                         input int r1, input bit u1, input int r2, input bit u2);
        bus.D_valid   = 1'b1;
        bus.D_addr_rd = 5'(rd);
        bus.D_We      = we;
        bus.D_rdy     = 2'(rdy);
        bus.D_addr_r1 = 5'(r1);
        bus.D_use_r1  = u1;
        bus.D_addr_r2 = 5'(r2);
        bus.D_use_r2  = u2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle_in();
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        chk("reset_valid", bus.stage_valid, 0);
        chk("reset_stall_cnt", bus.stall_cnt, 0);

        // ALU chaining
        issue(3, 1, 0, 0, 0, 0, 0);
        cyc();
        issue(9, 1, 0, 3, 1, 0, 0);
        #1;
        chk("alu_fwd1", bus.fwd1, 1);
        chk("alu_nostall", bus.D_stall, 0);
        cyc();
        idle_in();
        repeat (5) cyc();
        chk("alu_stall_cnt", bus.stall_cnt, 0);

        // load-use: two stall cycles then forward from stage 2
        issue(4, 1, 2, 0, 0, 0, 0);
        cyc();
        issue(10, 1, 0, 0, 0, 4, 1);
        #1;
        chk("lu_stall_a", bus.D_stall, 1);
        cyc();
        #1;
        chk("lu_stall_b", bus.D_stall, 1);
        chk("lu_fwd2_rf", bus.fwd2, 0);
        cyc();
        #1;
        chk("lu_released", bus.D_stall, 0);
        chk("lu_fwd2", bus.fwd2, 3);
        cyc();
        idle_in();
        #1;
        chk("lu_stall_cnt", bus.stall_cnt, 2);
        chk("model_stall_cnt", m_stall, 2);
        repeat (5) cyc();

        // youngest match wins; r0 never matches
        issue(5, 1, 0, 0, 0, 0, 0);
        cyc();
        issue(5, 1, 0, 0, 0, 0, 0);
        cyc();
        issue(0, 1, 2, 5, 1, 0, 0);
        #1;
        chk("young_fwd1", bus.fwd1, 1);
        chk("young_nostall", bus.D_stall, 0);
        cyc();
        issue(11, 1, 0, 0, 1, 0, 0);
        #1;
        chk("r0_fwd1", bus.fwd1, 0);
        chk("r0_nostall", bus.D_stall, 0);
        cyc();
        idle_in();
        repeat (5) cyc();

        // flush: branch in stage 2, load in stage 0, hazard in decode
        issue(0, 0, 0, 0, 0, 0, 0);
        cyc();
        issue(0, 0, 0, 0, 0, 0, 0);
        cyc();
        issue(6, 1, 2, 0, 0, 0, 0);
        cyc();
        issue(12, 1, 0, 6, 1, 0, 0);
        bus.br_taken = 1'b1;
        #1;
        chk("flush_pc_clear", bus.PC_clear, 1);
        chk("flush_hazard_stall", bus.D_stall, 1);
        chk("flush_pre_valid", bus.stage_valid, 4'b0111);
        cyc();
        idle_in();
        #1;
        chk("flush_post_valid", bus.stage_valid, 4'b1000);
        chk("flush_cnt", bus.flush_cnt, 1);
        chk("flush_stall_cnt", bus.stall_cnt, 3);
        chk("model_flush_cnt", m_flush, 1);

        // hold freezes shifting and suppresses the flush
        issue(7, 1, 0, 0, 0, 0, 0);
        cyc();
        issue(8, 1, 0, 0, 0, 0, 0);
        cyc();
        issue(13, 1, 0, 0, 0, 0, 0);
        cyc();
        idle_in();
        bus.hold     = 1'b1;
        bus.br_taken = 1'b1;
        #1;
        chk("hold_stall", bus.D_stall, 1);
        chk("hold_no_clear", bus.PC_clear, 0);
        chk("hold_valid_0", bus.stage_valid, 4'b0111);
        chk("hold_retire_0", bus.retire_cnt, 9);
        cyc();
        #1;
        chk("hold_valid_1", bus.stage_valid, 4'b0111);
        cyc();
        #1;
        chk("hold_valid_2", bus.stage_valid, 4'b0111);
        chk("hold_retire_2", bus.retire_cnt, 9);
        cyc();
        bus.hold     = 1'b0;
        bus.br_taken = 1'b0;
        #1;
        chk("hold_valid_rel", bus.stage_valid, 4'b0111);
        chk("hold_stall_cnt", bus.stall_cnt, 6);
        chk("hold_rel_nostall", bus.D_stall, 0);
        cyc();
        #1;
        chk("hold_resumed", bus.stage_valid, 4'b1110);
        chk("hold_retire_3", bus.retire_cnt, 9);
        cyc();
        #1;
        chk("hold_retire_4", bus.retire_cnt, 10);
        repeat (5) cyc();

        // asynchronous reset mid-operation
        issue(14, 1, 0, 0, 0, 0, 0);
        repeat (4) cyc();
        chk("full_valid", bus.stage_valid, 4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_valid", bus.stage_valid, 0);
        chk("areset_stall_cnt", bus.stall_cnt, 0);
        chk("areset_flush_cnt", bus.flush_cnt, 0);
        chk("areset_retire_cnt", bus.retire_cnt, 0);
        chk("areset_stall", bus.D_stall, 0);
        idle_in();
        cyc();
        cyc();
        rst_n = 1'b1;
        issue(15, 1, 0, 0, 0, 0, 0);
        cyc();
        #1;
        chk("resume_valid", bus.stage_valid, 4'b0001);
        chk("resume_retire", bus.retire_cnt, 0);
        idle_in();
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
